aes_uart_ctrl: RTL and testbench

Command sequencer between the UART byte receiver, the AES-128 core and the UART byte transmitter. Parses framed commands from the receive byte stream and assembles 16-byte key and plaintext blocks. Drives a start/done handshake to the AES core and serialises the 16-byte result (or a 1-byte ACK/NAK) back through the transmitter. Sits at the top of the AES-over-UART path; the only block that owns the AES core and the TX byte interface.

---
 rtl/aes_uart_pkg.sv | 27 ++
 rtl/aes_uart_ctrl_if.sv | 28 ++
 rtl/aes_uart_txser.sv | 54 +++++
 rtl/aes_uart_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_uart_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_uart_pkg.sv
// Shared command codes, block size and controller state encoding for the AES-over-UART path.
package aes_uart_pkg;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_KEY    = 3'd1,
        RX_BLK    = 3'd2,
        AES_START = 3'd3,
        AES_WAIT  = 3'd4,
        TX_LOAD   = 3'd5,
        TX_GAP    = 3'd6,
        TX_WAIT   = 3'd7
    } ctrl_state_t;

    // Single-byte responses go out MSB-first from the same 128-bit shifter as a ciphertext.
    function automatic logic [127:0] rsp_word(input logic [7:0] code);
        return {code, 120'd0};
    endfunction

endpackage

// File: rtl/aes_uart_ctrl_if.sv
// Byte receiver, AES core and byte transmitter signals seen by the command sequencer.
interface aes_uart_ctrl_if;

    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] aes_key;
    logic [127:0] aes_block_in;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_block_out;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic         busy;
    logic         err_timeout;
    logic         rx_overrun;

    modport master (
        input  rx_data, rx_valid, aes_done, aes_block_out, tx_busy,
        output aes_key, aes_block_in, aes_start, tx_data, tx_start, busy, err_timeout, rx_overrun
    );

    modport slave (
        output rx_data, rx_valid, aes_done, aes_block_out, tx_busy,
        input  aes_key, aes_block_in, aes_start, tx_data, tx_start, busy, err_timeout, rx_overrun
    );

endinterface

// File: rtl/aes_uart_txser.sv
// Response serialiser: sends 1 or 16 bytes MSB-first, one tx_start per byte, pacing on tx_busy.
module aes_uart_txser
    import aes_uart_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [4:0]   len,
    input  logic [127:0] data,
    input  logic         tx_busy,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         done
);

    ctrl_state_t  phase;
    logic [127:0] shreg;
    logic [4:0]   remaining;

    assign tx_data  = shreg[127:120];
    assign tx_start = (phase == TX_LOAD) && !tx_busy;
    assign done     = (phase == TX_WAIT) && !tx_busy && (remaining == 5'd1);

    // TX_GAP gives the transmitter one cycle to raise tx_busy after tx_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= IDLE;
            shreg     <= '0;
            remaining <= '0;
        end else if (load) begin
            phase     <= TX_LOAD;
            shreg     <= data;
            remaining <= len;
        end else begin
            case (phase)
                TX_LOAD: if (!tx_busy) phase <= TX_GAP;
                TX_GAP:  phase <= TX_WAIT;
                TX_WAIT: begin
                    if (!tx_busy) begin
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            phase <= IDLE;
                        end else begin
                            shreg <= {shreg[119:0], 8'h00};
                            phase <= TX_LOAD;
                        end
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/aes_uart_ctrl.sv
// Command sequencer: parses UART key/encrypt frames, runs the AES core and returns ACK/NAK or ciphertext.
//
// state     | meaning
// IDLE      | waiting for a command byte
// RX_KEY    | collecting 16 key bytes
// RX_BLK    | collecting 16 plaintext bytes
// AES_START | aes_start high for this one cycle
// AES_WAIT  | waiting for aes_done
// TX_LOAD   | response in flight; aes_uart_txser walks TX_LOAD/TX_GAP/TX_WAIT
module aes_uart_ctrl
    import aes_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 17360
) (
    input logic            clk,
    input logic            rst,
    aes_uart_ctrl_if.master bus
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t      state;
    logic             key_loaded;
    logic [3:0]       byte_cnt;
    logic [TMR_W-1:0] tmr;
    logic [119:0]     rx_shift;
    logic             last_byte;
    logic             tx_load;
    logic [4:0]       tx_len;
    logic [127:0]     tx_word;
    logic             tx_done;

    assign last_byte     = (byte_cnt == 4'(BLOCK_BYTES - 1));
    assign bus.busy      = (state != IDLE);
    assign bus.aes_start = (state == AES_START);

    always_comb begin
        tx_load = 1'b0;
        tx_len  = 5'd1;
        tx_word = rsp_word(RSP_NAK);
        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data != CMD_KEY &&
                    !(bus.rx_data == CMD_ENC && key_loaded))
                    tx_load = 1'b1;
            end
            RX_KEY: begin
                if (bus.rx_valid && last_byte) begin
                    tx_load = 1'b1;
                    tx_word = rsp_word(RSP_ACK);
                end
            end
            AES_WAIT: begin
                if (bus.aes_done) begin
                    tx_load = 1'b1;
                    tx_len  = 5'd16;
                    tx_word = bus.aes_block_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            key_loaded       <= 1'b0;
            byte_cnt         <= '0;
            tmr              <= '0;
            rx_shift         <= '0;
            bus.aes_key      <= '0;
            bus.aes_block_in <= '0;
            bus.err_timeout  <= 1'b0;
            bus.rx_overrun   <= 1'b0;
        end else begin
            bus.err_timeout <= 1'b0;
            bus.rx_overrun  <= 1'b0;
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    tmr      <= '0;
                    if (bus.rx_valid) begin
                        if (bus.rx_data == CMD_KEY)
                            state <= RX_KEY;
                        else if (bus.rx_data == CMD_ENC && key_loaded)
                            state <= RX_BLK;
                        else
                            state <= TX_LOAD;
                    end
                end
                RX_KEY, RX_BLK: begin
                    // A byte arriving on the terminal-count cycle beats the timeout.
                    if (bus.rx_valid) begin
                        tmr      <= '0;
                        rx_shift <= {rx_shift[111:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (last_byte) begin
                            if (state == RX_KEY) begin
                                bus.aes_key <= {rx_shift, bus.rx_data};
                                key_loaded  <= 1'b1;
                                state       <= TX_LOAD;
                            end else begin
                                bus.aes_block_in <= {rx_shift, bus.rx_data};
                                state            <= AES_START;
                            end
                        end
                    end else if (tmr == TMR_LAST) begin
                        bus.err_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                AES_START: state <= AES_WAIT;
                AES_WAIT:  if (bus.aes_done) state <= TX_LOAD;
                TX_LOAD:   if (tx_done) state <= IDLE;
                default:   state <= IDLE;
            endcase
            if (bus.rx_valid && !(state inside {IDLE, RX_KEY, RX_BLK}))
                bus.rx_overrun <= 1'b1;
        end
    end

    aes_uart_txser u_txser (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .len      (tx_len),
        .data     (tx_word),
        .tx_busy  (bus.tx_busy),
        .tx_data  (bus.tx_data),
        .tx_start (bus.tx_start),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Self-checking bench for aes_uart_ctrl: randomized frames against a frame-level reference model.
module tb_aes_uart_ctrl;

    localparam int TMO = 17360;
    localparam logic [7:0] K_CMD = 8'h4B;
    localparam logic [7:0] E_CMD = 8'h45;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h3F;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] FIPS_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    logic clk;
    logic rst;
    aes_uart_ctrl_if bus ();

    aes_uart_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_aes = 0;
    int n_tmo = 0;
    int n_ovr = 0;
    int aes_delay = 3;
    int long_hold = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [127:0] m_key = '0;
    logic m_loaded = 1'b0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Stand-in AES core: exact FIPS-197 vector, otherwise an arbitrary keyed mix.
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5A5A_1234_A5A5_9876_0F0F_CAFE_F0F0_BEEF;
    endfunction

    initial begin
        bus.aes_done = 1'b0;
        bus.aes_block_out = '0;
        forever begin
            @(negedge clk);
            if (bus.aes_start === 1'b1) begin
                logic [127:0] ct;
                n_aes++;
                ct = aes_model(bus.aes_key, bus.aes_block_in);
                repeat (aes_delay) @(posedge clk);
                #1;
                bus.aes_done = 1'b1;
                bus.aes_block_out = ct;
                @(posedge clk);
                #1;
                bus.aes_done = 1'b0;
                bus.aes_block_out = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Byte transmitter model: raises tx_busy after each tx_start and checks tx_data holds.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                logic [7:0] hold;
                int h;
                hold = bus.tx_data;
                got.push_back(hold);
                h = (long_hold != 0) ? 40 : int'($urandom_range(1, 4));
                @(posedge clk);
                #1;
                bus.tx_busy = 1'b1;
                repeat (h) begin
                    @(negedge clk);
                    if (bus.busy === 1'b1) begin
                        n_cmp++;
                        if (bus.tx_data !== hold) begin
                            n_bad++;
                            $display("FAIL tx_data_stable got %02h want %02h", bus.tx_data, hold);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.err_timeout === 1'b1) n_tmo++;
            if (bus.rx_overrun === 1'b1) n_ovr++;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [127:0] pl, input int gap_max);
        drive_byte(cmd);
        for (int i = 0; i < 16; i++) begin
            idle_cycles(int'($urandom_range(0, gap_max)));
            drive_byte(pl[127 - 8*i -: 8]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (k < 4000 && !(bus.busy === 1'b0 && bus.tx_busy === 1'b0)) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_wait busy=%b tx_busy=%b required both 0", tag, bus.busy, bus.tx_busy);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.aes_key, bus.aes_block_in, bus.tx_data, bus.aes_start, bus.tx_start,
             bus.busy, bus.err_timeout, bus.rx_overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs key=%h blk=%h txd=%h busy=%b required all 0",
                     bus.aes_key, bus.aes_block_in, bus.tx_data, bus.busy);
        end
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_nak_unloaded;
        int o0, a0;
        got.delete();
        o0 = n_ovr;
        a0 = n_aes;
        long_hold = 1;
        send_frame(E_CMD, {$urandom, $urandom, $urandom, $urandom}, 0);
        wait_idle("nak");
        long_hold = 0;
        n_cmp++;
        if (got.size() != 1) begin
            n_bad++;
            $display("FAIL nak_count got %0d bytes want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== NAK) begin
                n_bad++;
                $display("FAIL nak_byte got %02h want %02h", got[0], NAK);
            end
        end
        n_cmp++;
        if (n_ovr - o0 != 16) begin
            n_bad++;
            $display("FAIL nak_overrun got %0d want 16", n_ovr - o0);
        end
        n_cmp++;
        if (n_aes != a0) begin
            n_bad++;
            $display("FAIL nak_aes_start got %0d want 0", n_aes - a0);
        end
    endtask

    task automatic test_key_load;
        got.delete();
        send_frame(K_CMD, FIPS_KEY, 2);
        m_key = FIPS_KEY;
        m_loaded = 1'b1;
        wait_idle("key");
        n_cmp++;
        if (bus.aes_key !== FIPS_KEY) begin
            n_bad++;
            $display("FAIL key_value got %h want %h", bus.aes_key, FIPS_KEY);
        end
        n_cmp++;
        if (got.size() != 1 || got[0] !== ACK) begin
            n_bad++;
            $display("FAIL key_ack got %0d bytes first %02h want 1 byte %02h",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00, ACK);
        end
    endtask

    task automatic test_fips_encrypt;
        int a0;
        got.delete();
        exp_q.delete();
        a0 = n_aes;
        for (int i = 0; i < 16; i++) exp_q.push_back(FIPS_CT[127 - 8*i -: 8]);
        send_frame(E_CMD, FIPS_PT, 1);
        n_cmp++;
        if (bus.aes_start !== 1'b1) begin
            n_bad++;
            $display("FAIL enc_start_timing got %b want 1 one cycle after last byte", bus.aes_start);
        end
        n_cmp++;
        if (bus.aes_block_in !== FIPS_PT) begin
            n_bad++;
            $display("FAIL enc_block_in got %h want %h", bus.aes_block_in, FIPS_PT);
        end
        wait_idle("enc");
        n_cmp++;
        if (n_aes - a0 != 1) begin
            n_bad++;
            $display("FAIL enc_start_count got %0d want 1", n_aes - a0);
        end
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++;
            $display("FAIL enc_tx_count got %0d want 16", got.size());
        end
        foreach (exp_q[i]) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL enc_byte%0d got %02h want %02h", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int k, t0;
        logic hit;
        got.delete();
        t0 = n_tmo;
        drive_byte(K_CMD);
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom));
        k = 0;
        hit = 1'b0;
        while (k < TMO + 20 && !hit) begin
            @(posedge clk);
            #1;
            k++;
            hit = (bus.err_timeout === 1'b1);
        end
        n_cmp++;
        if (!hit || k < TMO - 1 || k > TMO) begin
            n_bad++;
            $display("FAIL tmo_latency got hit=%b after %0d cycles want pulse after %0d", hit, k, TMO);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_busy got %b want 0", bus.busy);
        end
        idle_cycles(10);
        n_cmp++;
        if (n_tmo - t0 != 1) begin
            n_bad++;
            $display("FAIL tmo_pulses got %0d want 1", n_tmo - t0);
        end
        n_cmp++;
        if (bus.aes_key !== m_key) begin
            n_bad++;
            $display("FAIL tmo_key got %h want %h", bus.aes_key, m_key);
        end
        n_cmp++;
        if (got.size() != 0) begin
            n_bad++;
            $display("FAIL tmo_no_tx got %0d bytes want 0", got.size());
        end
    endtask

    task automatic test_overrun;
        logic [127:0] blk, ct;
        int o0;
        blk = {$urandom, $urandom, $urandom, $urandom};
        ct = aes_model(m_key, blk);
        got.delete();
        aes_delay = 100;
        send_frame(E_CMD, blk, 1);
        o0 = n_ovr;
        for (int i = 0; i < 3; i++) begin
            idle_cycles(2);
            drive_byte(8'($urandom));
        end
        wait_idle("ovr");
        aes_delay = 3;
        n_cmp++;
        if (n_ovr - o0 != 3) begin
            n_bad++;
            $display("FAIL ovr_pulses got %0d want 3", n_ovr - o0);
        end
        n_cmp++;
        if (got.size() != 16) begin
            n_bad++;
            $display("FAIL ovr_tx_count got %0d want 16", got.size());
        end
        for (int i = 0; i < 16; i++) begin
            if (i < got.size()) begin
                n_cmp++;
                if (got[i] !== ct[127 - 8*i -: 8]) begin
                    n_bad++;
                    $display("FAIL ovr_byte%0d got %02h want %02h", i, got[i], ct[127 - 8*i -: 8]);
                end
            end
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 10; f++) begin
            int kind;
            logic [127:0] pl;
            logic [7:0] junk;
            logic [127:0] ct;
            kind = int'($urandom_range(0, 2));
            pl = {$urandom, $urandom, $urandom, $urandom};
            got.delete();
            exp_q.delete();
            if (kind == 0) begin
                send_frame(K_CMD, pl, 3);
                m_key = pl;
                m_loaded = 1'b1;
                exp_q.push_back(ACK);
            end else if (kind == 1 && m_loaded) begin
                send_frame(E_CMD, pl, 3);
                ct = aes_model(m_key, pl);
                for (int i = 0; i < 16; i++) exp_q.push_back(ct[127 - 8*i -: 8]);
            end else begin
                junk = 8'($urandom);
                while (junk == K_CMD || junk == E_CMD) junk = 8'($urandom);
                drive_byte(junk);
                exp_q.push_back(NAK);
            end
            wait_idle("rnd");
            n_cmp++;
            if (got.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rnd%0d_count got %0d want %0d", f, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                if (i < got.size()) begin
                    n_cmp++;
                    if (got[i] !== exp_q[i]) begin
                        n_bad++;
                        $display("FAIL rnd%0d_byte%0d got %02h want %02h", f, i, got[i], exp_q[i]);
                    end
                end
            end
            n_cmp++;
            if (bus.aes_key !== m_key) begin
                n_bad++;
                $display("FAIL rnd%0d_key got %h want %h", f, bus.aes_key, m_key);
            end
        end
    endtask

    task automatic test_reset_mid_tx;
        int k, a0;
        got.delete();
        send_frame(E_CMD, {$urandom, $urandom, $urandom, $urandom}, 1);
        k = 0;
        while (got.size() < 8 && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rst_reach_byte8 got %0d bytes want 8", got.size());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.aes_key, bus.aes_block_in, bus.tx_data, bus.aes_start, bus.tx_start,
             bus.busy, bus.err_timeout, bus.rx_overrun} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs key=%h txd=%h busy=%b start=%b required all 0",
                     bus.aes_key, bus.tx_data, bus.busy, bus.tx_start);
        end
        rst = 1'b0;
        m_key = '0;
        m_loaded = 1'b0;
        idle_cycles(20);
        n_cmp++;
        if (got.size() != 8) begin
            n_bad++;
            $display("FAIL rst_no_reissue got %0d bytes want 8", got.size());
        end
        wait_idle("rst");
        got.delete();
        a0 = n_aes;
        long_hold = 1;
        send_frame(E_CMD, {$urandom, $urandom, $urandom, $urandom}, 0);
        wait_idle("rst_nak");
        long_hold = 0;
        n_cmp++;
        if (got.size() != 1 || got[0] !== NAK) begin
            n_bad++;
            $display("FAIL rst_nak got %0d bytes first %02h want 1 byte %02h",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00, NAK);
        end
        n_cmp++;
        if (n_aes != a0) begin
            n_bad++;
            $display("FAIL rst_nak_aes got %0d starts want 0", n_aes - a0);
        end
    endtask

    initial begin
        test_reset();
        test_nak_unloaded();
        test_key_load();
        test_fips_encrypt();
        test_timeout();
        test_overrun();
        test_random_frames();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
